// File: rtl/sm_run_ctrl_pkg.sv
// ============================================================================
// Module      : sm_run_ctrl_pkg
// Description : Shared opcode and state encodings for the schoolMIPS
//               run/halt/step controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sm_run_ctrl_pkg;

  // Host command opcodes (cmd_op)
  typedef logic [1:0] rc_op_t;
  localparam rc_op_t RC_HALT   = 2'b00;
  localparam rc_op_t RC_RUN    = 2'b01;
  localparam rc_op_t RC_STEP   = 2'b10;
  localparam rc_op_t RC_CLRCNT = 2'b11;

  // Controller states (state output)
  localparam logic [1:0] RC_S_HALT  = 2'b00;
  localparam logic [1:0] RC_S_RUN   = 2'b01;
  localparam logic [1:0] RC_S_STEP  = 2'b10;
  localparam logic [1:0] RC_S_BREAK = 2'b11;

endpackage

`default_nettype wire

// File: rtl/sm_run_bp.sv
// ============================================================================
// Module      : sm_run_bp
// Description : PC breakpoint comparator with the one-shot skip flag that
//               lets execution resume past the breakpoint instruction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_run_bp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic        skip_set,
  input  logic        cpu_en,
  output logic        bp_match,
  output logic        skip
);

  // A match is suppressed while skip is armed so the breakpoint instruction
  // itself can execute once after resuming from BREAK.
  assign bp_match = bp_en && (pc == bp_addr) && !skip;

  // Skip arms on resume from BREAK and disarms on the first executed cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip <= 1'b0;
    end else if (skip_set) begin
      skip <= 1'b1;
    end else if (cpu_en) begin
      skip <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sm_run_ctrl.sv
// ============================================================================
// Module      : sm_run_ctrl
// Description : Run/halt/step sequencer driving the schoolMIPS core clock
//               enable, with a single PC breakpoint and an executed-cycle
//               counter.
// Options     : SM_RUN_CTRL_TIMEOUT_EN - halt RUN/STEP once cycle_cnt
//               reaches TIMEOUT and raise the sticky timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_run_ctrl
  import sm_run_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int STEP_W  = 16,
  parameter int TIMEOUT = 120
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              timeout
);

`ifdef SM_RUN_CTRL_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  // Last count value that may still execute before the limit is reached.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_r,   state_nxt;
  logic [STEP_W-1:0] remain_r,  remain_nxt;
  logic              bp_hit_r,  bp_hit_nxt;
  logic              timeout_r, timeout_nxt;
  logic [CNT_W-1:0]  cnt_r;

  logic fire;
  logic is_clr;
  logic skip_set;
  logic bp_match;
  logic skip;
  logic to_hit;

  // Breakpoint compare and resume-skip tracking
  sm_run_bp u_bp (
    .clk      (clk),
    .rst_n    (rst_n),
    .bp_en    (bp_en),
    .bp_addr  (bp_addr),
    .pc       (pc),
    .skip_set (skip_set),
    .cpu_en   (cpu_en),
    .bp_match (bp_match),
    .skip     (skip)
  );

  // Commands are refused only while a step burst is in flight.
  assign cmd_ready = (state_r != RC_S_STEP);
  assign fire      = cmd_valid && cmd_ready;
  assign is_clr    = fire && (cmd_op == RC_CLRCNT);
  assign skip_set  = fire && (state_r == RC_S_BREAK) &&
                     ((cmd_op == RC_RUN) || (cmd_op == RC_STEP));

  // Core clock enable decoded from registered state; breakpoints only gate RUN.
  always_comb begin
    case (state_r)
      RC_S_RUN:  cpu_en = !bp_match;
      RC_S_STEP: cpu_en = 1'b1;
      default:   cpu_en = 1'b0;
    endcase
  end

  // The limit fires on the cycle that executes the TIMEOUT-th instruction so
  // exactly TIMEOUT enabled cycles occur; a same-cycle CLRCNT cancels it.
  assign to_hit = TO_EN && cpu_en && !is_clr && (cnt_r >= TO_LAST) &&
                  ((state_r == RC_S_RUN) || (state_r == RC_S_STEP));

  // Next-state: autonomous progress first, then timeout, then host commands.
  always_comb begin
    state_nxt   = state_r;
    remain_nxt  = remain_r;
    bp_hit_nxt  = 1'b0;
    timeout_nxt = timeout_r;

    case (state_r)
      RC_S_RUN: begin
        if (bp_match) begin
          state_nxt  = RC_S_BREAK;
          bp_hit_nxt = 1'b1;
        end
      end
      RC_S_STEP: begin
        if (remain_r <= STEP_W'(1)) begin
          state_nxt  = RC_S_HALT;
          remain_nxt = '0;
        end else begin
          remain_nxt = remain_r - STEP_W'(1);
        end
      end
      default: ;
    endcase

    if (to_hit) begin
      state_nxt   = RC_S_HALT;
      remain_nxt  = '0;
      timeout_nxt = 1'b1;
    end

    if (fire) begin
      case (cmd_op)
        RC_HALT: begin
          state_nxt  = RC_S_HALT;
          remain_nxt = '0;
          bp_hit_nxt = 1'b0;
        end
        RC_RUN: begin
          state_nxt  = RC_S_RUN;
          bp_hit_nxt = 1'b0;
        end
        RC_STEP: begin
          state_nxt  = RC_S_STEP;
          remain_nxt = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
          bp_hit_nxt = 1'b0;
        end
        default: begin
          timeout_nxt = 1'b0;
        end
      endcase
    end
  end

  // Controller state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RC_S_HALT;
      remain_r  <= '0;
      bp_hit_r  <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      remain_r  <= remain_nxt;
      bp_hit_r  <= bp_hit_nxt;
      timeout_r <= timeout_nxt;
    end
  end

  // Executed-cycle counter; CLRCNT takes priority over the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (is_clr) begin
      cnt_r <= '0;
    end else if (cpu_en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign state     = state_r;
  assign bp_hit    = bp_hit_r;
  assign cycle_cnt = cnt_r;
  assign timeout   = timeout_r;

endmodule

`default_nettype wire

// File: tb/tb_sm_run_ctrl.sv
// ============================================================================
// Module      : tb_sm_run_ctrl
// Description : Self-checking bench for sm_run_ctrl: table-driven command
//               vectors plus directed breakpoint, reset and long-run sequences.
//               Expectations for the long run follow SM_RUN_CTRL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm_run_ctrl;
  import sm_run_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = RC_HALT;
  logic [15:0] cmd_arg = '0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] pc;
  logic        cpu_en;
  logic [1:0]  state;
  logic        bp_hit;
  logic [31:0] cycle_cnt;
  logic        timeout;

  int checks = 0;
  int failures = 0;

  sm_run_ctrl #(.CNT_W(32), .STEP_W(16), .TIMEOUT(120)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .cpu_en    (cpu_en),
    .state     (state),
    .bp_hit    (bp_hit),
    .cycle_cnt (cycle_cnt),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Tiny core model: PC advances when enabled; pc 6 branches back to 2.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 32'd0;
    else if (cpu_en) pc <= (pc == 32'd6) ? 32'd2 : pc + 32'd1;
  end

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [15:0] arg;
    logic [1:0]  st;
    logic        en;
    logic        rdy;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [1:0] op, input logic [15:0] arg,
                     input logic [1:0] st, input logic en, input logic rdy,
                     input logic [31:0] cnt);
    vq.push_back('{v, op, arg, st, en, rdy, cnt});
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next();
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] arg);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg;
    next();
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for a cycle with cpu_en low while running; leaves the
  // bench at that cycle's negedge.
  task automatic wait_stall(input string name);
    bit found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!cpu_en) begin
        found = 1;
        break;
      end
      next();
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    // ---------------- command table ----------------
    add(0, RC_HALT,   0, RC_S_HALT, 0, 1, 0);
    add(1, RC_RUN,    0, RC_S_HALT, 0, 1, 0);
    for (int i = 0; i < 9; i++) add(0, RC_HALT, 0, RC_S_RUN, 1, 1, 32'(i));
    add(1, RC_HALT,   0, RC_S_RUN,  1, 1, 9);
    add(0, RC_HALT,   0, RC_S_HALT, 0, 1, 10);
    add(0, RC_HALT,   0, RC_S_HALT, 0, 1, 10);
    // STEP 3
    add(1, RC_STEP,   3, RC_S_HALT, 0, 1, 10);
    add(0, RC_HALT,   0, RC_S_STEP, 1, 0, 10);
    add(0, RC_HALT,   0, RC_S_STEP, 1, 0, 11);
    add(0, RC_HALT,   0, RC_S_STEP, 1, 0, 12);
    add(0, RC_HALT,   0, RC_S_HALT, 0, 1, 13);
    // STEP 0 behaves as STEP 1
    add(1, RC_STEP,   0, RC_S_HALT, 0, 1, 13);
    add(0, RC_HALT,   0, RC_S_STEP, 1, 0, 13);
    add(0, RC_HALT,   0, RC_S_HALT, 0, 1, 14);
    // HALT held during STEP 2 is refused until the burst completes
    add(1, RC_STEP,   2, RC_S_HALT, 0, 1, 14);
    add(1, RC_HALT,   0, RC_S_STEP, 1, 0, 14);
    add(1, RC_HALT,   0, RC_S_STEP, 1, 0, 15);
    add(1, RC_HALT,   0, RC_S_HALT, 0, 1, 16);
    // CLRCNT while halted
    add(1, RC_CLRCNT, 0, RC_S_HALT, 0, 1, 16);
    add(0, RC_HALT,   0, RC_S_HALT, 0, 1, 0);
    // CLRCNT on an enabled cycle wins over the increment
    add(1, RC_RUN,    0, RC_S_HALT, 0, 1, 0);
    add(0, RC_HALT,   0, RC_S_RUN,  1, 1, 0);
    add(0, RC_HALT,   0, RC_S_RUN,  1, 1, 1);
    add(1, RC_CLRCNT, 0, RC_S_RUN,  1, 1, 2);
    add(0, RC_HALT,   0, RC_S_RUN,  1, 1, 0);
    add(0, RC_HALT,   0, RC_S_RUN,  1, 1, 1);
    add(1, RC_HALT,   0, RC_S_RUN,  1, 1, 2);
    add(0, RC_HALT,   0, RC_S_HALT, 0, 1, 3);

    reset_dut();
    @(negedge clk);
    chk("rst_state",   {30'd0, state}, {30'd0, RC_S_HALT});
    chk("rst_cpu_en",  {31'd0, cpu_en}, 32'd0);
    chk("rst_ready",   {31'd0, cmd_ready}, 32'd1);
    chk("rst_bp_hit",  {31'd0, bp_hit}, 32'd0);
    chk("rst_cnt",     cycle_cnt, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    next();

    for (int i = 0; i < vq.size(); i++) begin
      cmd_valid = vq[i].valid;
      cmd_op    = vq[i].op;
      cmd_arg   = vq[i].arg;
      @(negedge clk);
      chk($sformatf("v%0d_state", i), {30'd0, state}, {30'd0, vq[i].st});
      chk($sformatf("v%0d_cpu_en", i), {31'd0, cpu_en}, {31'd0, vq[i].en});
      chk($sformatf("v%0d_ready", i), {31'd0, cmd_ready}, {31'd0, vq[i].rdy});
      chk($sformatf("v%0d_cnt", i), cycle_cnt, vq[i].cnt);
      chk($sformatf("v%0d_bp_hit", i), {31'd0, bp_hit}, 32'd0);
      next();
    end
    cmd_valid = 1'b0;

    // ---------------- breakpoint at pc=4 ----------------
    reset_dut();
    bp_en = 1'b1;
    bp_addr = 32'd4;
    send(RC_RUN, 0);
    wait_stall("bp1_wait");
    chk("bp1_pc", pc, 32'd4);
    chk("bp1_state_run", {30'd0, state}, {30'd0, RC_S_RUN});
    next();
    @(negedge clk);
    chk("bp1_state", {30'd0, state}, {30'd0, RC_S_BREAK});
    chk("bp1_hit", {31'd0, bp_hit}, 32'd1);
    chk("bp1_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("bp1_cnt", cycle_cnt, 32'd4);
    next();
    @(negedge clk);
    chk("bp1_hit_pulse", {31'd0, bp_hit}, 32'd0);
    chk("bp1_hold", {30'd0, state}, {30'd0, RC_S_BREAK});
    next();

    // Resume: the breakpoint instruction executes once, loop breaks again
    send(RC_RUN, 0);
    @(negedge clk);
    chk("resume_pc", pc, 32'd4);
    chk("resume_cpu_en", {31'd0, cpu_en}, 32'd1);
    next();
    wait_stall("bp2_wait");
    chk("bp2_pc", pc, 32'd4);
    chk("bp2_cnt", cycle_cnt, 32'd9);
    next();
    @(negedge clk);
    chk("bp2_state", {30'd0, state}, {30'd0, RC_S_BREAK});
    chk("bp2_hit", {31'd0, bp_hit}, 32'd1);
    next();

    // HALT from BREAK, then STEP over the breakpoint (ignored in STEP)
    send(RC_HALT, 0);
    @(negedge clk);
    chk("brk_halt_state", {30'd0, state}, {30'd0, RC_S_HALT});
    next();
    send(RC_STEP, 1);
    @(negedge clk);
    chk("step_bp_cpu_en", {31'd0, cpu_en}, 32'd1);
    next();
    @(negedge clk);
    chk("step_bp_state", {30'd0, state}, {30'd0, RC_S_HALT});
    chk("step_bp_pc", pc, 32'd5);
    chk("step_bp_cnt", cycle_cnt, 32'd10);
    next();
    bp_en = 1'b0;

    // ---------------- asynchronous reset mid-RUN ----------------
    send(RC_RUN, 0);
    next();
    next();
    @(negedge clk);
    chk("pre_rst_cpu_en", {31'd0, cpu_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("async_rst_state", {30'd0, state}, {30'd0, RC_S_HALT});
    chk("async_rst_cnt", cycle_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next();

    // ---------------- long run / timeout ----------------
    send(RC_RUN, 0);
    repeat (200) next();
    @(negedge clk);
`ifdef SM_RUN_CTRL_TIMEOUT_EN
    chk("long_state", {30'd0, state}, {30'd0, RC_S_HALT});
    chk("long_timeout", {31'd0, timeout}, 32'd1);
    chk("long_cnt", cycle_cnt, 32'd120);
`else
    chk("long_state", {30'd0, state}, {30'd0, RC_S_RUN});
    chk("long_timeout", {31'd0, timeout}, 32'd0);
    chk("long_cnt", cycle_cnt, 32'd200);
    chk("long_cpu_en", {31'd0, cpu_en}, 32'd1);
`endif
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
